// File: rtl/epp_reg_bridge_if.sv
// epp_reg_bridge_if: GPU-side register bus of the EPP bridge (address, write/read strobes, read-return handshake).
interface epp_reg_bridge_if #(parameter int ADDR_W = 4);
    logic [ADDR_W-1:0] reg_addr;
    logic              wr_stb;
    logic [7:0]        wr_data;
    logic              rd_stb;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              busy;
    modport master (output reg_addr, wr_stb, wr_data, rd_stb, busy, input rd_data, rd_valid);
    modport slave  (input reg_addr, wr_stb, wr_data, rd_stb, busy, output rd_data, rd_valid);
endinterface

// File: rtl/epp_reg_bridge.sv
// epp_reg_bridge: EPP slave with synchronised strobes, full Wait handshake,
// single-cycle GPU strobes and a timed-out variable-latency read return.
module epp_reg_bridge #(
    parameter int         ADDR_W     = 4,
    parameter int         RD_TIMEOUT = 255,
    parameter logic [7:0] RD_DEFAULT = 8'hFF
) (
    input  logic       uclk,
    input  logic       rst_n,
    inout  wire  [7:0] EppDB,
    input  logic       EppAstb,
    input  logic       EppDstb,
    input  logic       EppWR,
    output logic       EppWait,
    epp_reg_bridge_if.master bus
);
    localparam int CW = $clog2(RD_TIMEOUT + 1);
    typedef enum logic [1:0] {INIT, IDLE, RD_PEND, HOLD} state_t;
    state_t state, state_n;
    logic [1:0] astb_q, dstb_q, wr_q;
    logic [7:0] db_q1, db_s;
    logic astb_s, dstb_s, wr_s;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0] wdat_n, out_buf, obuf_n;
    logic [CW-1:0] cnt, cnt_n;
    logic cyc_rd, rd_n, cyc_as, as_n, wstb_n, rstb_n, drv;
    assign astb_s = astb_q[1];
    assign dstb_s = dstb_q[1];
    assign wr_s = wr_q[1];
    assign EppDB = drv ? out_buf : 8'hzz;
    always_ff @(posedge uclk) begin
        astb_q <= {astb_q[0], EppAstb};
        dstb_q <= {dstb_q[0], EppDstb};
        wr_q <= {wr_q[0], EppWR};
        db_q1 <= EppDB;
        db_s <= db_q1;
    end
    always_comb begin
        state_n = state;
        addr_n = bus.reg_addr;
        wdat_n = bus.wr_data;
        obuf_n = out_buf;
        cnt_n = cnt;
        rd_n = cyc_rd;
        as_n = cyc_as;
        wstb_n = 1'b0;
        rstb_n = 1'b0;
        case (state)
            INIT: state_n = (astb_s && dstb_s) ? IDLE : INIT;
            IDLE: begin
                rd_n = wr_s;
                if (!astb_s) begin
                    as_n = 1'b1;
                    state_n = HOLD;
                    if (wr_s) obuf_n = 8'(bus.reg_addr);
                    else addr_n = db_s[ADDR_W-1:0];
                end else if (!dstb_s) begin
                    as_n = 1'b0;
                    if (wr_s) begin
                        rstb_n = 1'b1;
                        cnt_n = '0;
                        state_n = RD_PEND;
                    end else begin
                        wdat_n = db_s;
                        wstb_n = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            RD_PEND: begin
                if (bus.rd_valid) begin
                    obuf_n = bus.rd_data;
                    state_n = HOLD;
                end else if (cnt == CW'(RD_TIMEOUT)) begin
                    obuf_n = RD_DEFAULT;
                    state_n = HOLD;
                end else cnt_n = cnt + CW'(1);
            end
            default: state_n = (cyc_as ? astb_s : dstb_s) ? IDLE : HOLD;
        endcase
    end
    always_ff @(posedge uclk) begin
        if (!rst_n) begin
            state <= INIT;
            bus.reg_addr <= '0;
            bus.wr_data <= '0;
            bus.wr_stb <= 1'b0;
            bus.rd_stb <= 1'b0;
            bus.busy <= 1'b1;
            out_buf <= '0;
            cnt <= '0;
            cyc_rd <= 1'b0;
            cyc_as <= 1'b0;
            EppWait <= 1'b0;
            drv <= 1'b0;
        end else begin
            state <= state_n;
            bus.reg_addr <= addr_n;
            bus.wr_data <= wdat_n;
            bus.wr_stb <= wstb_n;
            bus.rd_stb <= rstb_n;
            bus.busy <= state_n != IDLE;
            out_buf <= obuf_n;
            cnt <= cnt_n;
            cyc_rd <= rd_n;
            cyc_as <= as_n;
            EppWait <= state_n == HOLD;
            drv <= state_n == HOLD && rd_n;
        end
    end
endmodule

// File: tb/tb_epp_reg_bridge.sv
// tb_epp_reg_bridge: directed host/GPU sequence against epp_reg_bridge with
// hand-computed latencies, strobe counts and bus values.
module tb_epp_reg_bridge;
    logic uclk = 1'b0;
    logic rst_n = 1'b0;
    logic astb = 1'b1, dstb = 1'b1, wr = 1'b0;
    logic host_drv = 1'b0;
    logic [7:0] host_db = 8'h00;
    wire [7:0] EppDB;
    logic EppWait;
    int checks = 0, errors = 0, wr_cnt = 0, rd_cnt = 0, n = 0, k = 0;
    logic [7:0] last_wd = 8'h00;
    logic stall_hi;
    epp_reg_bridge_if #(.ADDR_W(4)) bus ();
    assign EppDB = host_drv ? host_db : 8'hzz;
    epp_reg_bridge #(.ADDR_W(4), .RD_TIMEOUT(255), .RD_DEFAULT(8'hFF)) dut (
        .uclk(uclk),
        .rst_n(rst_n),
        .EppDB(EppDB),
        .EppAstb(astb),
        .EppDstb(dstb),
        .EppWR(wr),
        .EppWait(EppWait),
        .bus(bus)
    );
    always #5 uclk = ~uclk;
    always @(posedge uclk) begin
        if (bus.wr_stb) begin
            wr_cnt <= wr_cnt + 1;
            last_wd <= bus.wr_data;
        end
        if (bus.rd_stb) rd_cnt <= rd_cnt + 1;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_wait(input logic lvl, input int budget, output int cnt);
        cnt = 0;
        do begin
            @(negedge uclk);
            cnt++;
        end while (EppWait !== lvl && cnt < budget);
    endtask
    task automatic wait_rd(input int base);
        k = 0;
        do begin
            @(negedge uclk);
            k++;
        end while (rd_cnt == base && k < 10);
    endtask
    initial begin
        bus.rd_valid = 1'b0;
        bus.rd_data = 8'h00;
        repeat (3) @(negedge uclk);
        chk("rst_wait", 32'(EppWait), 0);
        chk("rst_busy", 32'(bus.busy), 1);
        chk("rst_addr", 32'(bus.reg_addr), 0);
        chk("rst_wdata", 32'(bus.wr_data), 0);
        chk("rst_stb", 32'({bus.wr_stb, bus.rd_stb}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge uclk);
        chk("idle_busy", 32'(bus.busy), 0);
        host_drv = 1'b1; host_db = 8'h0E; wr = 1'b0; astb = 1'b0;
        wait_wait(1'b1, 10, n);
        chk("aw_lat", n, 3);
        chk("aw_addr", 32'(bus.reg_addr), 32'hE);
        astb = 1'b1;
        wait_wait(1'b0, 10, n);
        chk("aw_rel", n, 3);
        chk("aw_nostb", wr_cnt + rd_cnt, 0);
        host_db = 8'h03; astb = 1'b0;
        wait_wait(1'b1, 10, n);
        astb = 1'b1;
        wait_wait(1'b0, 10, n);
        host_db = 8'hA5; dstb = 1'b0;
        wait_wait(1'b1, 10, n);
        chk("dw_wait", 32'(EppWait), 1);
        chk("dw_data", 32'(bus.wr_data), 32'hA5);
        chk("dw_addr", 32'(bus.reg_addr), 3);
        dstb = 1'b1;
        wait_wait(1'b0, 10, n);
        chk("dw_cnt", wr_cnt, 1);
        chk("dw_last", 32'(last_wd), 32'hA5);
        host_drv = 1'b0; wr = 1'b1; dstb = 1'b0;
        wait_rd(0);
        chk("rd_stb", rd_cnt, 1);
        stall_hi = 1'b0;
        repeat (10) begin
            @(negedge uclk);
            stall_hi |= EppWait;
        end
        chk("rd_stall", 32'(stall_hi), 0);
        bus.rd_data = 8'h5C; bus.rd_valid = 1'b1;
        @(negedge uclk);
        bus.rd_valid = 1'b0; bus.rd_data = 8'h00;
        chk("rd_wait", 32'(EppWait), 1);
        chk("rd_data", 32'(EppDB), 32'h5C);
        dstb = 1'b1;
        wait_wait(1'b0, 10, n);
        chk("rd_rel", n, 3);
        host_drv = 1'b1; host_db = 8'h00;
        #1;
        chk("rd_hiz", 32'(EppDB), 0);
        chk("rd_single", rd_cnt, 1);
        host_drv = 1'b0; dstb = 1'b0;
        wait_wait(1'b1, 300, n);
        chk("to_lat", n, 259);
        chk("to_data", 32'(EppDB), 32'hFF);
        dstb = 1'b1;
        wait_wait(1'b0, 10, n);
        chk("to_cnt", rd_cnt, 2);
        wr = 1'b0; host_drv = 1'b1; host_db = 8'h07; astb = 1'b0; dstb = 1'b0;
        wait_wait(1'b1, 10, n);
        chk("both_addr", 32'(bus.reg_addr), 7);
        astb = 1'b1;
        wait_wait(1'b0, 10, n);
        chk("both_nowr", wr_cnt, 1);
        wait_wait(1'b1, 10, n);
        chk("both_dlat", n, 1);
        dstb = 1'b1;
        wait_wait(1'b0, 10, n);
        chk("both_wr", wr_cnt, 2);
        chk("both_last", 32'(last_wd), 32'h07);
        host_drv = 1'b0; wr = 1'b1; dstb = 1'b0;
        wait_rd(2);
        repeat (3) @(negedge uclk);
        rst_n = 1'b0;
        repeat (2) @(negedge uclk);
        chk("rst2_wait", 32'(EppWait), 0);
        chk("rst2_busy", 32'(bus.busy), 1);
        host_drv = 1'b1; host_db = 8'h00;
        #1;
        chk("rst2_hiz", 32'(EppDB), 0);
        host_drv = 1'b0; rst_n = 1'b1;
        repeat (20) @(negedge uclk);
        chk("rst2_nostb", rd_cnt, 3);
        chk("rst2_init", 32'(bus.busy), 1);
        dstb = 1'b1;
        repeat (4) @(negedge uclk);
        chk("rst2_idle", 32'(bus.busy), 0);
        dstb = 1'b0;
        wait_rd(3);
        chk("rst2_newrd", rd_cnt, 4);
        bus.rd_data = 8'h11; bus.rd_valid = 1'b1;
        @(negedge uclk);
        bus.rd_valid = 1'b0;
        chk("rst2_data", 32'(EppDB), 32'h11);
        dstb = 1'b1;
        wait_wait(1'b0, 10, n);
        chk("rst2_cnt", rd_cnt, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
